mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Sub-word load/store sequencer between the EX/MEM pipeline boundary and the word-only data memory.
- Accepts one load or store request per handshake.
- Performs word-aligned reads, or read-modify-write for byte/halfword stores.
- Sign- or zero-extends load results and returns them with a one-cycle response pulse.
- The pipeline stalls while req_ready is low.

Parameters:
MEM_WORDS, 64, number of 32-bit words in data memory; word index = addr[31:2]; index >= MEM_WORDS is out of range.

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle, can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned in bits [7:0] or [15:0] for sub-word stores
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  extended load data, valid with resp_valid
resp_err  output  1  misaligned, illegal size or out of range; valid with resp_valid
mem_address  output  32  to data memory, always word-aligned (bits [1:0] = 0)
mem_write_data  output  32  to data memory
mem_write  output  1  to data memory; write committed at rising CLK
mem_read  output  1  to data memory
mem_read_data  input  32  from data memory

Behaviour:
- Reset values: state IDLE, req_ready=1, all other outputs 0, latched request cleared. Forward buffer invalid if the optional feature is compiled in.
- Byte lanes are little-endian: byte offset k occupies bits [8k+7:8k]. A half at offset 0 uses bits [15:0]; at offset 2 it uses bits [31:16].
- Handshake: a request is accepted at the rising edge where req_valid=1 and state=IDLE. All req_* fields are latched at that edge. req_valid while busy is ignored; the requester holds it.
- States: IDLE, RD, CAP, WR, DONE.
  - IDLE -> DONE with error: when misaligned (half with addr[0]=1; word with addr[1:0]!=0), size=11, or addr[31:2] >= MEM_WORDS. No memory access occurs.
  - IDLE -> WR: word store.
  - IDLE -> RD: load or sub-word store.
  - RD: mem_read=1, mem_address={addr[31:2],2'b00}.
  - RD -> CAP: mem_read stays 1; mem_read_data is sampled into the read buffer at the end of CAP.
  - CAP -> DONE: load. CAP -> WR: sub-word store.
  - WR: mem_write=1 for exactly one cycle. mem_write_data = req_wdata for word stores, or the read buffer with the target lane(s) replaced.
  - WR -> DONE.
  - DONE: resp_valid=1 for one cycle. resp_rdata is the extracted lane: sign-extended if req_signed, else zero-extended; word loads pass through unchanged. resp_rdata=0 for stores and errors. Then DONE -> IDLE.
- mem_read and mem_write are never high in the same cycle. Both are 0 outside RD/CAP/WR.
- Latency, counted in cycles after the accept edge:
  - Load: resp_valid in cycle 3.
  - Word store: cycle 2.
  - Sub-word store: cycle 4.
  - Error: cycle 1.
- Throughput: next accept is no earlier than the cycle after DONE.
- Reset mid-operation: the state machine returns to IDLE asynchronously and mem_write drops immediately, so an in-flight WR does not commit. No response is issued for the aborted request.

Optional Feature:
MAU_STORE_FWD_EN
- Defined:
  - A one-entry forward buffer holds {valid, word index, word} from the last committed WR.
  - A load whose word index matches goes IDLE -> DONE using the buffered word, with resp_valid in cycle 1 and no mem_read.
  - The buffer is updated on every WR commit and invalidated on reset.
  - A sub-word store that hits also skips RD/CAP: IDLE -> WR, merging into the buffered word.
- Undefined: no buffer; all loads and sub-word stores take the full RD/CAP path.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0. Store resp in cycle 2, load resp in cycle 3; mem_address=0x10.
- With word 0x80FF7F01 at 0x20: lb 0x20 -> 0x00000001; lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
- With 0x11223344 at 0x30: sb 0xAA to 0x31, then lw 0x30 -> 0x1122AA44; sh 0xBEEF to 0x32, then lw -> 0xBEEFAA44. Sub-word store resp in cycle 4; exactly one mem_write pulse each.
- lh 0x05, lw 0x06, size=11, and lw at 4*MEM_WORDS (0x100) -> each gives resp_err=1 in cycle 1, resp_rdata=0, no mem_read/mem_write.
- Assert RST_N low during the WR cycle of sw 0x12345678 to 0x40 (prior content 0) -> mem_write drops at once, req_ready=1. After release, lw 0x40 -> 0x00000000.
- MAU_STORE_FWD_EN: sw 0xCAFEF00D to 0x44, then lw 0x44 -> resp in cycle 1, mem_read never asserted; lw 0x48 -> normal 3-cycle path.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for mem_access_unit.
// slave = unit side, master = pipeline/memory side.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_signed,
      input  req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_address, mem_write_data, mem_write, mem_read
   );

   modport master (
      output req_valid, req_write, req_size, req_signed,
      output req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_address, mem_write_data, mem_write, mem_read
   );
endinterface

// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer in front of a word-only data memory.
// Define MAU_STORE_FWD_EN for the one-entry store-forward buffer.
module mem_access_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic             CLK,
   input  logic             RST_N,
   mem_access_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

   state_e      state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        bad;
   logic        fwd_hit;
   logic [31:0] fwd_word;
   logic [31:0] merged;
   logic [31:0] loaded;

   function automatic logic [31:0] merge(
      input logic [31:0] w,
      input logic [31:0] d,
      input logic [1:0]  sz,
      input logic [1:0]  off
   );
      logic [31:0] r;
      r = w;
      case (sz)
         2'b00: r[{off, 3'b000} +: 8] = d[7:0];
         2'b01: begin
            if (off[1]) r[31:16] = d[15:0];
            else        r[15:0]  = d[15:0];
         end
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extract(
      input logic [31:0] w,
      input logic [1:0]  sz,
      input logic [1:0]  off,
      input logic        sgn
   );
      logic [31:0] r;
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      bad = 1'b0;
      case (bus.req_size)
         2'b01:   bad = bus.req_addr[0];
         2'b10:   bad = |bus.req_addr[1:0];
         2'b11:   bad = 1'b1;
         default: bad = 1'b0;
      endcase
      if (bus.req_addr[31:2] >= 30'(MEM_WORDS)) bad = 1'b1;
   end

   assign merged = merge(rbuf_q, wdata_q, size_q, addr_q[1:0]);
   assign loaded = extract(rbuf_q, size_q, addr_q[1:0], sgn_q);

`ifdef MAU_STORE_FWD_EN
   logic        fwd_vld_q, fwd_vld_d;
   logic [29:0] fwd_idx_q, fwd_idx_d;
   logic [31:0] fwd_word_q, fwd_word_d;

   // Mirrors the word most recently committed to memory.
   always_comb begin
      fwd_vld_d  = fwd_vld_q;
      fwd_idx_d  = fwd_idx_q;
      fwd_word_d = fwd_word_q;
      if (state_q == WR) begin
         fwd_vld_d  = 1'b1;
         fwd_idx_d  = addr_q[31:2];
         fwd_word_d = merged;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fwd_vld_q  <= 1'b0;
         fwd_idx_q  <= '0;
         fwd_word_q <= '0;
      end else begin
         fwd_vld_q  <= fwd_vld_d;
         fwd_idx_q  <= fwd_idx_d;
         fwd_word_q <= fwd_word_d;
      end
   end

   assign fwd_hit  = fwd_vld_q && (fwd_idx_q == bus.req_addr[31:2]);
   assign fwd_word = fwd_word_q;
`else
   assign fwd_hit  = 1'b0;
   assign fwd_word = '0;
`endif

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               size_d  = bus.req_size;
               sgn_d   = bus.req_signed;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               err_d   = bad;
               if (bad) begin
                  state_d = DONE;
               end else if (bus.req_write && bus.req_size == 2'b10) begin
                  state_d = WR;
               end else if (fwd_hit) begin
                  rbuf_d  = fwd_word;
                  state_d = bus.req_write ? WR : DONE;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:  state_d = CAP;
         CAP: begin
            rbuf_d  = bus.mem_read_data;
            state_d = wr_q ? WR : DONE;
         end
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
      end
   end

   // Strobes decode straight from state so reset kills a pending write.
   always_comb begin
      bus.req_ready      = (state_q == IDLE);
      bus.mem_read       = (state_q == RD) || (state_q == CAP);
      bus.mem_write      = (state_q == WR);
      bus.mem_address    = '0;
      bus.mem_write_data = '0;
      if (state_q == RD || state_q == CAP || state_q == WR)
         bus.mem_address = {addr_q[31:2], 2'b00};
      if (state_q == WR)
         bus.mem_write_data = merged;
      bus.resp_valid = (state_q == DONE);
      bus.resp_err   = (state_q == DONE) && err_q;
      bus.resp_rdata = '0;
      if (state_q == DONE && !wr_q && !err_q)
         bus.resp_rdata = loaded;
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a word memory model.
// Build with +define+MAU_STORE_FWD_EN to cover the forward buffer.
module tb_mem_access_unit;
   logic CLK;
   logic RST_N;

   mem_access_unit_if bus ();

   mem_access_unit #(.MEM_WORDS(64)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] mem [0:63] = '{default: 32'h0};

   always @(posedge CLK) begin
      if (bus.mem_write)
         mem[bus.mem_address[7:2]] <= bus.mem_write_data;
      if (bus.mem_read)
         bus.mem_read_data <= mem[bus.mem_address[7:2]];
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;
   logic        fwd_vld = 1'b0;
   logic [29:0] fwd_idx = '0;

   function automatic vec_t mk(
      input logic wr, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, input logic [31:0] wdata,
      input logic [31:0] rdata, input logic err,
      input int lat, input int nrd, input int nwr
   );
      vec_t v;
      v.wr = wr; v.size = size; v.sgn = sgn;
      v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.err = err;
      v.lat = lat; v.nrd = nrd; v.nwr = nwr;
      return v;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int          lat;
      int          nrd;
      int          got_lat;
      int          srd;
      int          swr;
      logic [31:0] got_rd;
      logic        got_err;
      logic [31:0] addr_seen;
      lat = v.lat;
      nrd = v.nrd;
      srd = 0;
      swr = 0;
      got_lat = 0;
      got_rd = '0;
      got_err = 1'b0;
      addr_seen = '0;
`ifdef MAU_STORE_FWD_EN
      if (!v.err && fwd_vld && fwd_idx == v.addr[31:2]
          && !(v.wr && v.size == 2'b10)) begin
         lat = v.wr ? 2 : 1;
         nrd = 0;
      end
`endif
      if (v.nwr != 0) begin
         fwd_vld = 1'b1;
         fwd_idx = v.addr[31:2];
      end
      bus.req_write  = v.wr;
      bus.req_size   = v.size;
      bus.req_signed = v.sgn;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      for (int i = 0; i < 20 && !bus.req_ready; i++) begin
         @(posedge CLK); #1;
      end
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (bus.mem_read) begin
            srd++;
            addr_seen = bus.mem_address;
         end
         if (bus.mem_write) begin
            swr++;
            addr_seen = bus.mem_address;
         end
         if (bus.mem_read && bus.mem_write) overlap++;
         if (bus.resp_valid) begin
            got_lat = c;
            got_rd  = bus.resp_rdata;
            got_err = bus.resp_err;
         end
         @(posedge CLK); #1;
         if (got_lat != 0) break;
      end
      chk({tag, ".lat"}, 32'(got_lat), 32'(lat));
      chk({tag, ".rdata"}, got_rd, v.rdata);
      chk({tag, ".err"}, 32'(got_err), 32'(v.err));
      chk({tag, ".nrd"}, 32'(srd), 32'(nrd));
      chk({tag, ".nwr"}, 32'(swr), 32'(v.nwr));
      chk({tag, ".pulse"}, 32'(bus.resp_valid), 32'd0);
      if (nrd + v.nwr > 0)
         chk({tag, ".maddr"}, addr_seen, {v.addr[31:2], 2'b00});
   endtask

   vec_t tbl [22];
   int   rv_seen;

   initial begin
      tbl[0]  = mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1);
      tbl[1]  = mk(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 2, 0);
      tbl[2]  = mk(1, 2'd2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0, 2, 0, 1);
      tbl[3]  = mk(0, 2'd0, 1, 32'h20, 32'h0, 32'h00000001, 0, 3, 2, 0);
      tbl[4]  = mk(0, 2'd0, 1, 32'h23, 32'h0, 32'hFFFFFF80, 0, 3, 2, 0);
      tbl[5]  = mk(0, 2'd0, 0, 32'h23, 32'h0, 32'h00000080, 0, 3, 2, 0);
      tbl[6]  = mk(0, 2'd1, 1, 32'h22, 32'h0, 32'hFFFF80FF, 0, 3, 2, 0);
      tbl[7]  = mk(0, 2'd1, 0, 32'h20, 32'h0, 32'h00007F01, 0, 3, 2, 0);
      tbl[8]  = mk(1, 2'd2, 0, 32'h30, 32'h11223344, 32'h0, 0, 2, 0, 1);
      tbl[9]  = mk(1, 2'd0, 0, 32'h31, 32'h123456AA, 32'h0, 0, 4, 2, 1);
      tbl[10] = mk(0, 2'd2, 0, 32'h30, 32'h0, 32'h1122AA44, 0, 3, 2, 0);
      tbl[11] = mk(1, 2'd1, 0, 32'h32, 32'h5555BEEF, 32'h0, 0, 4, 2, 1);
      tbl[12] = mk(0, 2'd2, 0, 32'h30, 32'h0, 32'hBEEFAA44, 0, 3, 2, 0);
      tbl[13] = mk(0, 2'd0, 1, 32'h31, 32'h0, 32'hFFFFFFAA, 0, 3, 2, 0);
      tbl[14] = mk(0, 2'd1, 0, 32'h32, 32'h0, 32'h0000BEEF, 0, 3, 2, 0);
      tbl[15] = mk(0, 2'd1, 1, 32'h05, 32'h0, 32'h0, 1, 1, 0, 0);
      tbl[16] = mk(0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1, 1, 0, 0);
      tbl[17] = mk(0, 2'd3, 0, 32'h30, 32'h0, 32'h0, 1, 1, 0, 0);
      tbl[18] = mk(0, 2'd2, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0);
      tbl[19] = mk(1, 2'd0, 0, 32'h101, 32'hFF, 32'h0, 1, 1, 0, 0);
      tbl[20] = mk(1, 2'd1, 0, 32'h33, 32'hFFFF, 32'h0, 1, 1, 0, 0);
      tbl[21] = mk(0, 2'd2, 0, 32'hFC, 32'h0, 32'h0, 0, 3, 2, 0);

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset.ready", 32'(bus.req_ready), 32'd1);
      chk("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset.mem_read", 32'(bus.mem_read), 32'd0);
      chk("reset.mem_write", 32'(bus.mem_write), 32'd0);
      chk("reset.mem_address", bus.mem_address, 32'h0);
      chk("reset.resp_rdata", bus.resp_rdata, 32'h0);
      #3 RST_N = 1'b1;
      @(posedge CLK); #1;

      for (int i = 0; i < 22; i++)
         run_vec($sformatf("v%0d", i), tbl[i]);

      // Abort a word store in its WR cycle.
      bus.req_write  = 1'b1;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h40;
      bus.req_wdata  = 32'h12345678;
      bus.req_valid  = 1'b1;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      chk("rst.wr_cycle", 32'(bus.mem_write), 32'd1);
      RST_N = 1'b0;
      #1;
      chk("rst.mem_write_drop", 32'(bus.mem_write), 32'd0);
      chk("rst.ready", 32'(bus.req_ready), 32'd1);
      rv_seen = 0;
      repeat (2) begin
         @(posedge CLK); #1;
         if (bus.resp_valid) rv_seen++;
      end
      #3 RST_N = 1'b1;
      @(posedge CLK); #1;
      if (bus.resp_valid) rv_seen++;
      chk("rst.no_resp", 32'(rv_seen), 32'd0);
      fwd_vld = 1'b0;

      run_vec("post_rst_lw40",
              mk(0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 0, 3, 2, 0));
      run_vec("fwd_sw44",
              mk(1, 2'd2, 0, 32'h44, 32'hCAFEF00D, 32'h0, 0, 2, 0, 1));
      run_vec("fwd_lw44",
              mk(0, 2'd2, 0, 32'h44, 32'h0, 32'hCAFEF00D, 0, 3, 2, 0));
      run_vec("fwd_lw48",
              mk(0, 2'd2, 0, 32'h48, 32'h0, 32'h0, 0, 3, 2, 0));

      chk("rd_wr_overlap", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
